// File: rtl/div_clk_monitor_pkg.sv
// div_mon_pkg: shared FSM state type and sizing helpers for div_clk_monitor.
package div_mon_pkg;
   typedef enum logic [1:0] {IDLE, ARM, MEASURE, DONE} state_e;
   localparam int GATE_CYCLES_DEF = 64;
   localparam int EXP_DIV_DEF = 4;
   localparam int CNT_W_DEF = 8;
   function automatic int gate_w(input int gate_cycles);
      return $clog2(gate_cycles + 1);
   endfunction
   function automatic int exp_edges(input int gate_cycles, input int exp_div);
      return gate_cycles / exp_div;
   endfunction
endpackage

// File: rtl/div_clk_monitor_if.sv
// div_clk_monitor_if: request/result bundle between a divider checker and its user.
interface div_clk_monitor_if #(parameter int CNT_W = 8);
   logic             clk_div_in;
   logic             start;
   logic             busy;
   logic             done;
   logic             locked;
   logic             err;
   logic [CNT_W-1:0] edge_cnt;
   logic [CNT_W-1:0] period;
   modport master (output clk_div_in, start, input busy, done, locked, err, edge_cnt, period);
   modport slave (input clk_div_in, start, output busy, done, locked, err, edge_cnt, period);
endinterface

// File: rtl/div_clk_monitor_edge_det.sv
// div_edge_det: samples the divided clock as data and flags its rising edges.
// DIV_MON_SYNC_EN adds a 2-flop synchronizer ahead of the sampling flop.
module div_edge_det (
   input  logic fin,
   input  logic rst,
   input  logic din,
   output logic edge_o
);
   logic s_q, sd_q;
`ifdef DIV_MON_SYNC_EN
   logic meta_q, sync_q;
   always_ff @(posedge fin) begin
      meta_q <= rst ? 1'b0 : din;
      sync_q <= rst ? 1'b0 : meta_q;
      s_q    <= rst ? 1'b0 : sync_q;
   end
`else
   always_ff @(posedge fin) s_q <= rst ? 1'b0 : din;
`endif
   always_ff @(posedge fin) sd_q <= rst ? 1'b0 : s_q;
   assign edge_o = s_q & ~sd_q;
endmodule

// File: rtl/div_clk_monitor.sv
// div_clk_monitor: gated edge count and edge-to-edge period check of a divided clock.
// Define DIV_MON_SYNC_EN to synchronize clk_div_in before edge detection.
module div_clk_monitor
   import div_mon_pkg::*;
#(
   parameter int GATE_CYCLES = GATE_CYCLES_DEF,
   parameter int EXP_DIV = EXP_DIV_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input logic fin,
   input logic rst,
   div_clk_monitor_if.slave bus
);
   localparam int GW = gate_w(GATE_CYCLES);
   localparam logic [GW-1:0] GATE_V = GW'(GATE_CYCLES);
   localparam logic [CNT_W-1:0] EDGES_V = CNT_W'(exp_edges(GATE_CYCLES, EXP_DIV));
   localparam logic [CNT_W-1:0] DIV_V = CNT_W'(EXP_DIV);
   state_e state_q, state_d;
   logic [GW-1:0] to_q, to_d, gate_q, gate_d;
   logic [CNT_W-1:0] acc_q, acc_d, per_q, per_d, last_q, last_d;
   logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d, period_q, period_d, per_inc;
   logic locked_q, locked_d, err_q, err_d, edge_w;

   div_edge_det u_edge (.fin(fin), .rst(rst), .din(bus.clk_div_in), .edge_o(edge_w));

   assign per_inc = per_q == '1 ? per_q : per_q + 1'b1;

   always_comb begin
      state_d = state_q;
      to_d = to_q;
      gate_d = gate_q;
      acc_d = acc_q;
      per_d = per_q;
      last_d = last_q;
      edge_cnt_d = edge_cnt_q;
      period_d = period_q;
      locked_d = locked_q;
      err_d = err_q;
      case (state_q)
         IDLE: begin
            to_d = '0;
            if (bus.start) begin
               state_d = ARM;
               edge_cnt_d = '0;
               period_d = '0;
               locked_d = 1'b0;
               err_d = 1'b0;
            end
         end
         ARM: begin
            to_d = to_q + 1'b1;
            if (edge_w) begin
               state_d = MEASURE;
               gate_d = GW'(1);
               acc_d = CNT_W'(1);
               per_d = '0;
               last_d = '0;
            end else if (to_d == GATE_V) begin
               state_d = DONE;
               err_d = 1'b1;
               acc_d = '0;
               last_d = '0;
            end
         end
         MEASURE: begin
            // gate_d counts the current cycle, so the edge cycle in ARM is gate cycle 1
            gate_d = gate_q + 1'b1;
            acc_d = edge_w ? acc_q + 1'b1 : acc_q;
            last_d = edge_w ? per_inc : last_q;
            per_d = edge_w ? '0 : per_inc;
            state_d = gate_d == GATE_V ? DONE : MEASURE;
         end
         DONE: begin
            edge_cnt_d = acc_q;
            period_d = last_q;
            locked_d = (acc_q == EDGES_V) && (last_q == DIV_V) && !err_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge fin) begin
      if (rst) begin
         state_q <= IDLE;
         to_q <= '0;
         gate_q <= '0;
         acc_q <= '0;
         per_q <= '0;
         last_q <= '0;
         edge_cnt_q <= '0;
         period_q <= '0;
         locked_q <= 1'b0;
         err_q <= 1'b0;
      end else begin
         state_q <= state_d;
         to_q <= to_d;
         gate_q <= gate_d;
         acc_q <= acc_d;
         per_q <= per_d;
         last_q <= last_d;
         edge_cnt_q <= edge_cnt_d;
         period_q <= period_d;
         locked_q <= locked_d;
         err_q <= err_d;
      end
   end

   assign bus.busy = state_q == ARM || state_q == MEASURE;
   assign bus.done = state_q == DONE;
   assign bus.edge_cnt = edge_cnt_q;
   assign bus.period = period_q;
   assign bus.locked = locked_q;
   assign bus.err = err_q;
endmodule
